uart_rx: RTL and testbench

// Serial UART receiver, counterpart of the uartTx transmitter: 8N1-style framing, LSB first, idle-high line.

---
 rtl/uart_rx.sv | 163 ++++++++++++++++
 tb/tb_uart_rx.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 2-flop line synchroniser, centre-sampling framing FSM and receive FIFO.
// Good words are queued; framing and overrun conditions raise sticky status bits.
module uart_rx #(
  parameter int DIV    = 16,
  parameter int DWIDTH = 8,
  parameter int FDEPTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sIn,
  input  logic              dataRen,
  output logic [DWIDTH-1:0] dataOut,
  output logic              fifoEmpty,
  output logic              fifoFull,
  output logic              rxBusy,
  output logic              frameErr,
  output logic              overrunErr,
  input  logic              errClr
);
  localparam int SW = $clog2(DIV);
  localparam int BW = $clog2(DWIDTH) + 1;
  localparam int AW = $clog2(FDEPTH);
  localparam int CW = AW + 1;

  localparam logic [SW-1:0] HALF_M1 = SW'(DIV / 2 - 1);
  localparam logic [SW-1:0] FULL_M1 = SW'(DIV - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DWIDTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FDEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_e;

  logic              rx_meta_q, rx_s_q;
  state_e            state_q, state_d;
  logic [SW-1:0]     sample_cnt_q, sample_cnt_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DWIDTH-1:0] shift_q, shift_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_err_q, overrun_err_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DWIDTH-1:0] data_out_q, data_out_d;
  logic [DWIDTH-1:0] mem [FDEPTH];

  logic fifo_wr, fifo_rd, frame_set, overrun_set, full;

  assign full = (count_q == FULL_CNT);

  // NOTE: every output of this block gets a default first so no path can leave a value unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    fifo_wr      = 1'b0;
    frame_set    = 1'b0;
    overrun_set  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d      = S_START;
          sample_cnt_d = '0;
        end
      end
      S_START: begin
        if (sample_cnt_q == HALF_M1) begin
          sample_cnt_d = '0;
          bit_cnt_d    = '0;
          state_d      = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          sample_cnt_d = sample_cnt_q + SW'(1);
        end
      end
      S_DATA: begin
        if (sample_cnt_q == FULL_M1) begin
          sample_cnt_d = '0;
          shift_d      = {rx_s_q, shift_q[DWIDTH-1:1]};
          if (bit_cnt_q == LAST_BIT) state_d = S_STOP;
          else                       bit_cnt_d = bit_cnt_q + BW'(1);
        end else begin
          sample_cnt_d = sample_cnt_q + SW'(1);
        end
      end
      S_STOP: begin
        if (sample_cnt_q == FULL_M1) begin
          sample_cnt_d = '0;
          if (rx_s_q) begin
            // Fullness is judged before any same-cycle read, so that case is an overrun.
            if (full) overrun_set = 1'b1;
            else      fifo_wr     = 1'b1;
            state_d = S_IDLE;
          end else begin
            frame_set = 1'b1;
            state_d   = S_BREAK;
          end
        end else begin
          sample_cnt_d = sample_cnt_q + SW'(1);
        end
      end
      S_BREAK: if (rx_s_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    fifo_rd       = dataRen && (count_q != '0);
    wr_ptr_d      = fifo_wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d      = fifo_rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
    data_out_d    = fifo_rd ? mem[rd_ptr_q] : data_out_q;
    count_d       = count_q + CW'(fifo_wr) - CW'(fifo_rd);
    // A set in the same cycle as errClr wins.
    frame_err_d   = (frame_err_q & ~errClr) | frame_set;
    overrun_err_d = (overrun_err_q & ~errClr) | overrun_set;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q     <= 1'b1;
      rx_s_q        <= 1'b1;
      state_q       <= S_IDLE;
      sample_cnt_q  <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      data_out_q    <= '0;
    end else begin
      rx_meta_q     <= sIn;
      rx_s_q        <= rx_meta_q;
      state_q       <= state_d;
      sample_cnt_q  <= sample_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      frame_err_q   <= frame_err_d;
      overrun_err_q <= overrun_err_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      data_out_q    <= data_out_d;
    end
  end

  // NOTE: FIFO storage is not reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (fifo_wr) mem[wr_ptr_q] <= shift_q;
  end

  assign dataOut    = data_out_q;
  assign fifoEmpty  = (count_q == '0);
  assign fifoFull   = full;
  assign rxBusy     = (state_q != S_IDLE);
  assign frameErr   = frame_err_q;
  assign overrunErr = overrun_err_q;
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table-driven frames, hand-written corner sequences
// and randomized frame bursts checked against a queue-based reference model.
module tb_uart_rx;
  localparam int DIV    = 8;
  localparam int FDEPTH = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s_in = 1'b1;
  logic       data_ren = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] data_out;
  logic       fifo_empty, fifo_full, rx_busy, frame_err, overrun_err;

  int n_vec  = 0;
  int n_fail = 0;

  logic [7:0] exp_q[$];
  logic       model_ferr, model_ovr;

  uart_rx #(.DIV(DIV), .DWIDTH(8), .FDEPTH(FDEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .sIn        (s_in),
    .dataRen    (data_ren),
    .dataOut    (data_out),
    .fifoEmpty  (fifo_empty),
    .fifoFull   (fifo_full),
    .rxBusy     (rx_busy),
    .frameErr   (frame_err),
    .overrunErr (overrun_err),
    .errClr     (err_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "time limit");
  end

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_empty;
    logic       exp_ferr;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Transmitter model: start bit, 8 data bits LSB first, stop bit held stop_len clocks.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int stop_len);
    s_in = 1'b0;
    tick(DIV);
    for (int i = 0; i < 8; i++) begin
      s_in = d[i];
      tick(DIV);
    end
    s_in = stop;
    tick(stop_len);
  endtask

  task automatic read_word(output logic [7:0] w);
    data_ren = 1'b1;
    tick(1);
    data_ren = 1'b0;
    w = data_out;
  endtask

  task automatic clear_errors();
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
  endtask

  task automatic drain_and_check(input string name);
    logic [7:0] w, e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      read_word(w);
      check(name, {24'h0, w}, {24'h0, e});
    end
    check({name, "_empty"}, {31'h0, fifo_empty}, 32'd1);
  endtask

  initial begin
    vec_t       vecs[6];
    logic [7:0] w, b;
    logic       bad;
    int         n, gap;

    vecs[0] = '{data: 8'hA5, stop: 1'b1, exp_empty: 1'b0, exp_ferr: 1'b0};
    vecs[1] = '{data: 8'h00, stop: 1'b1, exp_empty: 1'b0, exp_ferr: 1'b0};
    vecs[2] = '{data: 8'hFF, stop: 1'b1, exp_empty: 1'b0, exp_ferr: 1'b0};
    vecs[3] = '{data: 8'h55, stop: 1'b1, exp_empty: 1'b0, exp_ferr: 1'b0};
    vecs[4] = '{data: 8'h81, stop: 1'b1, exp_empty: 1'b0, exp_ferr: 1'b0};
    vecs[5] = '{data: 8'h3C, stop: 1'b0, exp_empty: 1'b1, exp_ferr: 1'b1};

    // Reset state
    tick(3);
    check("rst_busy", {31'h0, rx_busy}, 32'd0);
    check("rst_empty", {31'h0, fifo_empty}, 32'd1);
    check("rst_full", {31'h0, fifo_full}, 32'd0);
    check("rst_ferr", {31'h0, frame_err}, 32'd0);
    check("rst_ovr", {31'h0, overrun_err}, 32'd0);
    check("rst_dout", {24'h0, data_out}, 32'd0);
    rst = 1'b0;
    tick(4);

    // Table-driven single frames
    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].data, vecs[i].stop, DIV);
      check("vec_empty", {31'h0, fifo_empty}, {31'h0, vecs[i].exp_empty});
      check("vec_ferr", {31'h0, frame_err}, {31'h0, vecs[i].exp_ferr});
      if (!vecs[i].exp_empty) begin
        read_word(w);
        check("vec_data", {24'h0, w}, {24'h0, vecs[i].data});
      end
      s_in = 1'b1;
      tick(4);
      check("vec_idle", {31'h0, rx_busy}, 32'd0);
      clear_errors();
    end

    // Back-to-back burst, rxBusy returns low afterwards
    exp_q = '{8'h00, 8'hFF, 8'h55, 8'h81};
    foreach (exp_q[i]) send_frame(exp_q[i], 1'b1, DIV);
    tick(2);
    check("b2b_busy", {31'h0, rx_busy}, 32'd0);
    drain_and_check("b2b_data");

    // False start: 3-clk low glitch
    s_in = 1'b0;
    tick(3);
    s_in = 1'b1;
    tick(1);
    check("glitch_busy_hi", {31'h0, rx_busy}, 32'd1);
    tick(12);
    check("glitch_busy_lo", {31'h0, rx_busy}, 32'd0);
    check("glitch_empty", {31'h0, fifo_empty}, 32'd1);
    check("glitch_ferr", {31'h0, frame_err}, 32'd0);

    // Bad stop bit followed by a 40-clk break
    send_frame(8'h3C, 1'b0, DIV);
    tick(40);
    check("break_busy", {31'h0, rx_busy}, 32'd1);
    check("break_empty", {31'h0, fifo_empty}, 32'd1);
    check("break_ferr", {31'h0, frame_err}, 32'd1);
    s_in = 1'b1;
    tick(4);
    check("break_exit", {31'h0, rx_busy}, 32'd0);
    send_frame(8'h12, 1'b1, DIV);
    read_word(w);
    check("after_break_data", {24'h0, w}, 32'h12);
    check("ferr_sticky", {31'h0, frame_err}, 32'd1);
    clear_errors();
    check("ferr_cleared", {31'h0, frame_err}, 32'd0);

    // Set beats clear: errClr held high across a bad stop sample
    err_clr = 1'b1;
    send_frame(8'h99, 1'b0, DIV - 1);
    check("set_wins", {31'h0, frame_err}, 32'd1);
    tick(1);
    check("clr_after_set", {31'h0, frame_err}, 32'd0);
    err_clr = 1'b0;
    s_in = 1'b1;
    tick(4);

    // Randomized bursts against the queue model
    model_ferr = 1'b0;
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(2, 6);
      for (int k = 0; k < n; k++) begin
        bad = ($urandom_range(0, 7) == 0);
        b = 8'($urandom);
        send_frame(b, !bad, DIV);
        if (bad) begin
          model_ferr = 1'b1;
          s_in = 1'b1;
          gap = $urandom_range(3, 10);
        end else begin
          exp_q.push_back(b);
          gap = $urandom_range(0, 10);
        end
        tick(gap);
      end
      tick(2);
      check("rand_ferr", {31'h0, frame_err}, {31'h0, model_ferr});
      check("rand_nonempty", {31'h0, fifo_empty}, {31'h0, exp_q.size() == 0});
      drain_and_check("rand_data");
      clear_errors();
      model_ferr = 1'b0;
    end

    // Overrun: FDEPTH+1 frames with no reads
    model_ovr = 1'b0;
    for (int i = 0; i < FDEPTH + 1; i++) begin
      b = 8'($urandom);
      if (exp_q.size() == FDEPTH) model_ovr = 1'b1;
      else                        exp_q.push_back(b);
      send_frame(b, 1'b1, DIV);
    end
    check("ovr_full", {31'h0, fifo_full}, 32'd1);
    check("ovr_flag", {31'h0, overrun_err}, {31'h0, model_ovr});
    clear_errors();
    model_ovr = 1'b0;
    check("ovr_cleared", {31'h0, overrun_err}, 32'd0);

    // Read in the same cycle as the stop-bit write while full: still an overrun
    b = 8'($urandom);
    if (exp_q.size() == FDEPTH) model_ovr = 1'b1;
    else                        exp_q.push_back(b);
    send_frame(b, 1'b1, DIV - 2);
    read_word(w);
    check("race_data", {24'h0, w}, {24'h0, exp_q.pop_front()});
    tick(2);
    check("race_ovr", {31'h0, overrun_err}, {31'h0, model_ovr});
    check("race_full", {31'h0, fifo_full}, 32'd0);
    drain_and_check("ovr_data");
    clear_errors();

    // Asynchronous reset during data bit 4
    send_frame(8'h44, 1'b0, DIV);
    s_in = 1'b1;
    tick(4);
    send_frame(8'h11, 1'b1, DIV);
    s_in = 1'b0;
    tick(DIV);
    for (int i = 0; i < 4; i++) begin
      s_in = b[i];
      s_in = 8'h7E >> i;
      tick(DIV);
    end
    s_in = 1'b1;
    tick(DIV / 2);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy", {31'h0, rx_busy}, 32'd0);
    check("mid_rst_empty", {31'h0, fifo_empty}, 32'd1);
    check("mid_rst_ferr", {31'h0, frame_err}, 32'd0);
    check("mid_rst_ovr", {31'h0, overrun_err}, 32'd0);
    tick(2);
    rst = 1'b0;
    tick(4);
    send_frame(8'h7E, 1'b1, DIV);
    read_word(w);
    check("post_rst_data", {24'h0, w}, 32'h7E);
    check("post_rst_empty", {31'h0, fifo_empty}, 32'd1);
    check("post_rst_ferr", {31'h0, frame_err}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
